// File: rtl/axis_frame_regulator.sv
// Video AXI-Stream frame regulator: rebuilds exact W x H frames from raw input.
// Pads short lines, truncates long lines and closes frames cut short by an early SOF.
module axis_frame_regulator #(
    parameter int C_PIXEL_WIDTH  = 8,
    parameter int C_IMG_WBITS    = 12,
    parameter int C_IMG_HBITS    = 12,
    parameter int C_PAD_VALUE    = 0,
    parameter int C_ERR_CNT_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      soft_resetn,
    input  logic [C_IMG_WBITS-1:0]    img_width,
    input  logic [C_IMG_HBITS-1:0]    img_height,
    input  logic                      s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0]  s_axis_tdata,
    input  logic                      s_axis_tuser,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic                      m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0]  m_axis_tdata,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [31:0]               frame_cnt,
    output logic [C_ERR_CNT_BITS-1:0] short_line_cnt,
    output logic [C_ERR_CNT_BITS-1:0] long_line_cnt,
    output logic [C_ERR_CNT_BITS-1:0] early_sof_cnt
);

    typedef enum logic [2:0] {
        WAIT_SOF,
        PASS,
        PAD_LINE,
        PAD_FRAME,
        DROP
    } state_t;

    localparam logic [C_IMG_WBITS-1:0]    W_ONE = 1;
    localparam logic [C_IMG_HBITS-1:0]    H_ONE = 1;
    localparam logic [C_ERR_CNT_BITS-1:0] E_ONE = 1;
    localparam logic [C_PIXEL_WIDTH-1:0]  PAD   = C_PIXEL_WIDTH'(C_PAD_VALUE);

    state_t                   state;
    logic [C_IMG_WBITS-1:0]   w_q, col, cur_w, cur_col;
    logic [C_IMG_HBITS-1:0]   h_q, row, cur_h, cur_row;
    logic                     adv, sof_hold, take, sof_ok;
    logic                     col_last, row_last, frame_done;

    assign adv      = ~m_axis_tvalid | m_axis_tready;
    assign sof_hold = s_axis_tvalid & s_axis_tuser;
    assign take     = s_axis_tvalid & s_axis_tready;
    assign sof_ok   = (img_width != '0) & (img_height != '0);

    // A SOF seen mid-frame is never consumed; it is held until WAIT_SOF.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!reset && soft_resetn) begin
            unique case (state)
                WAIT_SOF: s_axis_tready = adv;
                PASS:     s_axis_tready = adv & ~sof_hold;
                DROP:     s_axis_tready = ~sof_hold;
                default:  s_axis_tready = 1'b0;
            endcase
        end
    end

    // The SOF beat is judged against the live geometry, later beats against the latch.
    always_comb begin
        cur_w   = w_q;
        cur_h   = h_q;
        cur_col = col;
        cur_row = row;
        if (state == WAIT_SOF) begin
            cur_w   = img_width;
            cur_h   = img_height;
            cur_col = '0;
            cur_row = '0;
        end
        col_last   = (cur_col == cur_w - W_ONE);
        row_last   = (cur_row == cur_h - H_ONE);
        frame_done = col_last & row_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT_SOF;
            w_q            <= '0;
            h_q            <= '0;
            col            <= '0;
            row            <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tuser   <= 1'b0;
            m_axis_tlast   <= 1'b0;
            frame_cnt      <= '0;
            short_line_cnt <= '0;
            long_line_cnt  <= '0;
            early_sof_cnt  <= '0;
        end else if (!soft_resetn) begin
            state         <= WAIT_SOF;
            col           <= '0;
            row           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (adv) m_axis_tvalid <= 1'b0;
            unique case (state)
                WAIT_SOF, PASS: begin
                    if (state == PASS && sof_hold) begin
                        if (~&early_sof_cnt) early_sof_cnt <= early_sof_cnt + E_ONE;
                        state <= PAD_FRAME;
                    end else if (take && (state == PASS || (s_axis_tuser && sof_ok))) begin
                        if (state == WAIT_SOF) begin
                            w_q <= img_width;
                            h_q <= img_height;
                        end
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tuser  <= (cur_col == '0) && (cur_row == '0);
                        m_axis_tlast  <= col_last;
                        if (col_last) begin
                            col <= '0;
                            row <= frame_done ? '0 : cur_row + H_ONE;
                            if (!s_axis_tlast && ~&long_line_cnt)
                                long_line_cnt <= long_line_cnt + E_ONE;
                            if (frame_done) begin
                                frame_cnt <= frame_cnt + 32'd1;
                                state     <= WAIT_SOF;
                            end else begin
                                state <= s_axis_tlast ? PASS : DROP;
                            end
                        end else begin
                            col <= cur_col + W_ONE;
                            row <= cur_row;
                            if (s_axis_tlast && ~&short_line_cnt)
                                short_line_cnt <= short_line_cnt + E_ONE;
                            state <= s_axis_tlast ? PAD_LINE : PASS;
                        end
                    end
                end
                PAD_LINE, PAD_FRAME: begin
                    if (adv) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= PAD;
                        m_axis_tuser  <= 1'b0;
                        m_axis_tlast  <= col_last;
                        if (col_last) begin
                            col <= '0;
                            row <= frame_done ? '0 : row + H_ONE;
                            if (frame_done) begin
                                frame_cnt <= frame_cnt + 32'd1;
                                state     <= WAIT_SOF;
                            end else if (state == PAD_LINE) begin
                                state <= PASS;
                            end
                        end else begin
                            col <= col + W_ONE;
                        end
                    end
                end
                DROP: begin
                    if (sof_hold) begin
                        if (~&early_sof_cnt) early_sof_cnt <= early_sof_cnt + E_ONE;
                        state <= PAD_FRAME;
                    end else if (take && s_axis_tlast) begin
                        state <= PASS;
                    end
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_regulator.sv
// Directed bench for axis_frame_regulator with W=4/H=2 frames.
// Output beats are captured at negedge and compared against hand-built lists.
module tb_axis_frame_regulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        soft_resetn = 1'b1;
    logic [11:0] img_width = 12'd4;
    logic [11:0] img_height = 12'd2;
    logic        s_tvalid = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [31:0] frame_cnt;
    logic [7:0]  short_cnt, long_cnt, early_cnt;

    int errors = 0;
    int checks = 0;
    int w;
    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    bit toggle_en = 1'b0;
    bit prev_stall = 1'b0;
    logic [10:0] prev_beat = '0;

    axis_frame_regulator dut (
        .clk           (clk),
        .reset         (reset),
        .soft_resetn   (soft_resetn),
        .img_width     (img_width),
        .img_height    (img_height),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .frame_cnt     (frame_cnt),
        .short_line_cnt(short_cnt),
        .long_line_cnt (long_cnt),
        .early_sof_cnt (early_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Capture handshakes and verify the output holds while stalled.
    always @(negedge clk) begin
        if (prev_stall && !reset)
            check("hold", 32'({m_tvalid, m_tuser, m_tlast, m_tdata}), 32'(prev_beat));
        if (m_tvalid && m_tready)
            got.push_back({m_tuser, m_tlast, m_tdata});
        prev_stall = m_tvalid && !m_tready && !reset;
        prev_beat  = {m_tvalid, m_tuser, m_tlast, m_tdata};
    end

    always @(posedge clk) begin
        if (toggle_en) begin
            #1;
            m_tready = ~m_tready;
        end
    end

    task automatic send(input logic [7:0] d, input logic u, input logic l, output int waits);
        bit hs;
        bit done;
        waits = 0;
        done = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = d;
        s_tuser = u;
        s_tlast = l;
        while (!done) begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 100) begin
                    check("send_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_line(input logic [7:0] base, input int n, input bit sof,
                             input bit last, output int w0);
        int wt;
        w0 = 0;
        for (int i = 0; i < n; i++) begin
            send(base + 8'(i), sof && i == 0, last && i == n - 1, wt);
            if (i == 0) w0 = wt;
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [7:0] base, input int n, input bit sof, input int pads);
        int tot;
        tot = n + pads;
        for (int i = 0; i < tot; i++) begin
            if (i < n)
                exp_q.push_back({sof && i == 0, i == tot - 1, base + 8'(i)});
            else
                exp_q.push_back({1'b0, i == tot - 1, 8'h00});
        end
    endtask

    task automatic cmp_out(input string tag);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        exp_q.delete();
        got.delete();
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        img_width = 12'd4;
        img_height = 12'd2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag, input int f, input int s, input int l, input int e);
        check({tag, "_frame"}, frame_cnt, 32'(f));
        check({tag, "_short"}, 32'(short_cnt), 32'(s));
        check({tag, "_long"}, 32'(long_cnt), 32'(l));
        check({tag, "_early"}, 32'(early_cnt), 32'(e));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check_cnts("rst", 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // clean frame
        send_line(8'h10, 4, 1, 1, w);
        send_line(8'h14, 4, 0, 1, w);
        idle(8);
        push_line(8'h10, 4, 1, 0);
        push_line(8'h14, 4, 0, 0);
        cmp_out("clean");
        check_cnts("clean", 1, 0, 0, 0);

        // short line 0: one pad beat, one input stall
        do_reset();
        send_line(8'h20, 3, 1, 1, w);
        send_line(8'h30, 4, 0, 1, w);
        check("short_stall", 32'(w), 32'd1);
        idle(8);
        push_line(8'h20, 3, 1, 1);
        push_line(8'h30, 4, 0, 0);
        cmp_out("short");
        check_cnts("short", 1, 1, 0, 0);

        // long line 0: truncated, two beats dropped
        do_reset();
        send_line(8'h40, 6, 1, 1, w);
        send_line(8'h50, 4, 0, 1, w);
        check("long_nostall", 32'(w), 32'd0);
        idle(8);
        push_line(8'h40, 4, 1, 0);
        push_line(8'h50, 4, 0, 0);
        cmp_out("long");
        check_cnts("long", 1, 0, 1, 0);

        // early SOF after 5 pixels
        do_reset();
        send_line(8'h60, 4, 1, 1, w);
        send_line(8'h70, 1, 0, 0, w);
        send_line(8'h80, 4, 1, 1, w);
        check("early_hold", 32'(w), 32'd4);
        check_cnts("early_mid", 1, 0, 0, 1);
        send_line(8'h84, 4, 0, 1, w);
        idle(8);
        push_line(8'h60, 4, 1, 0);
        push_line(8'h70, 1, 0, 3);
        push_line(8'h80, 4, 1, 0);
        push_line(8'h84, 4, 0, 0);
        cmp_out("early");
        check_cnts("early_end", 2, 0, 0, 1);

        // pre-SOF garbage and a zero-width SOF are dropped
        do_reset();
        send_line(8'h90, 3, 0, 0, w);
        check("drop_ready", 32'(w), 32'd0);
        img_width = 12'd0;
        send(8'h93, 1'b1, 1'b0, w);
        check("w0_ready", 32'(w), 32'd0);
        idle(6);
        check("drop_tvalid", 32'(m_tvalid), 32'd0);
        check("drop_none", 32'(got.size()), 32'd0);
        img_width = 12'd4;

        // single-pixel lines
        do_reset();
        img_width = 12'd1;
        send(8'hA0, 1'b1, 1'b1, w);
        send(8'hA1, 1'b0, 1'b1, w);
        idle(6);
        push_line(8'hA0, 1, 1, 0);
        push_line(8'hA1, 1, 0, 0);
        cmp_out("w1");
        check_cnts("w1", 1, 0, 0, 0);

        // downstream back-pressure toggling every cycle
        do_reset();
        toggle_en = 1'b1;
        send_line(8'hB0, 4, 1, 1, w);
        send_line(8'hB4, 4, 0, 1, w);
        idle(12);
        toggle_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_tready = 1'b1;
        idle(4);
        push_line(8'hB0, 4, 1, 0);
        push_line(8'hB4, 4, 0, 0);
        cmp_out("stall");
        check_cnts("stall", 1, 0, 0, 0);

        // reset mid-line, then recover at next SOF
        do_reset();
        send_line(8'hC0, 2, 1, 0, w);
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_tdata", 32'(m_tdata), 32'd0);
        check("mid_rst_tuser", 32'(m_tuser), 32'd0);
        reset = 1'b0;
        got.delete();
        @(posedge clk);
        #1;
        send(8'hCF, 1'b0, 1'b1, w);
        send_line(8'hD0, 4, 1, 1, w);
        send_line(8'hD4, 4, 0, 1, w);
        idle(8);
        push_line(8'hD0, 4, 1, 0);
        push_line(8'hD4, 4, 0, 0);
        cmp_out("recover");
        check_cnts("recover", 1, 0, 0, 0);

        // soft reset blocks input and keeps counters
        s_tvalid = 1'b1;
        s_tuser = 1'b1;
        soft_resetn = 1'b0;
        #1;
        check("soft_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        check("soft_tvalid", 32'(m_tvalid), 32'd0);
        soft_resetn = 1'b1;
        idle(2);
        check("soft_frame", frame_cnt, 32'd1);
        check("soft_none", 32'(got.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
